ab_load_arbiter: RTL and testbench
==================================

// Module: ab_load_arbiter
// PURPOSE
//  Shares the single internal-memory write port between the activation (a) and weight (b)
//  valid/ready input streams while one tile is loaded. Eligible streams are granted round-robin.
//  Each beat is written to its own address region. When both streams have delivered a full
//  tile, data_ready pulses once, which moves the convolution controller from LOAD to FETCH.
// PARAMETERS
//  DATA_WIDTH    16    width of a_data/b_data/mem_wdata
//  ADDR_WIDTH    12    internal memory address width
//  A_TILE_WORDS  288   a beats per tile; written at addr 0..A_TILE_WORDS-1
//  B_TILE_WORDS  576   b beats per tile; written at B_BASE_ADDR..B_BASE_ADDR+B_TILE_WORDS-1
//  B_BASE_ADDR   512   base of b region; must be >=A_TILE_WORDS, region must fit 2**ADDR_WIDTH
// PORTS
//  clk          in   1           single clock, rising edge
//  arst_in      in   1           asynchronous reset, active-high
//  start        in   1           1-cycle pulse: begin loading one tile (ignored unless IDLE)
//  busy         out  1           1 in LOAD and DONE
//  a_valid      in   1           a beat offered
//  a_data       in   DATA_WIDTH  a beat payload
//  a_ready      out  1           a beat accepted this cycle when a_valid&&a_ready
//  b_valid      in   1           b beat offered
//  b_data       in   DATA_WIDTH  b beat payload
//  b_ready      out  1           b beat accepted this cycle when b_valid&&b_ready
//  mem_we       out  1           registered write enable to internal memory
//  mem_waddr    out  ADDR_WIDTH  registered write address
//  mem_wdata    out  DATA_WIDTH  registered write data
//  data_ready   out  1           1-cycle pulse: tile complete
//  tiles_loaded out  16          completed-tile count, wraps 65535->0
// BEHAVIOUR
//  Reset: state=IDLE, a_cnt=b_cnt=0, last_grant=B, every output 0. Reset mid-LOAD discards the partial tile.
//  FSM: IDLE --start--> LOAD; LOAD --(a_cnt==A_TILE_WORDS && b_cnt==B_TILE_WORDS)--> DONE;
//       DONE --(unconditional, 1 cycle)--> IDLE.
//  Eligible: a_elig = LOAD && a_valid && a_cnt<A_TILE_WORDS; b_elig likewise with b_cnt.
//  Grant is combinational and only in LOAD; at most one of a_ready/b_ready is 1 per cycle.
//   - Exactly one stream eligible: that stream is granted.
//   - Both eligible: the stream opposite last_grant is granted.
//   - last_grant updates only on an accepted beat.
//  ready may depend on valid; valid never depends on ready. A completed stream holds ready=0.
//  Accepted beat at cycle t:
//   - cnt increments.
//   - At t+1: mem_we=1, mem_waddr = cnt_at_t (a) or B_BASE_ADDR+cnt_at_t (b), mem_wdata = beat data.
//   - Latency is exactly 1 cycle. No beat is dropped or duplicated.
//  DONE cycle: data_ready=1. This coincides with the final mem_we when the last beat was accepted
//   in the previous cycle. Counters clear to 0. tiles_loaded increments modulo 2**16.
//  start while busy: ignored, no side effects.
//  start and reset in the same cycle: reset wins.
//  Zero-beat cycles in LOAD (no valid): no state change. The FSM waits indefinitely; there is no timeout.
// CONFIGURATION
//  LOAD_ARB_B_PRIORITY_EN defined:
//   - When both streams are eligible, b always wins (fixed priority); last_grant is unused.
//   - a is served only when b_valid=0 or b is complete.
//  LOAD_ARB_B_PRIORITY_EN undefined: round-robin as above (default build).
// STRUCTURE
//  Package load_arb_pkg:
//   - typedef enum logic [1:0] {LA_IDLE, LA_LOAD, LA_DONE} load_arb_state_t;
//   - typedef enum logic {GRANT_A, GRANT_B} grant_t;
//   - localparam TILES_CNT_W = 16.
//  One sub-module, tile_word_counter (params MAX, W): clear, inc, count, full=(count==MAX).
//   Instantiated twice, for a_cnt and b_cnt.
// TESTING
//  1 Reset then idle: arst_in=1 for 3 cycles -> all outputs 0. start with no valid -> busy=1, mem_we=0 forever.
//  2 Alternating contention: a_valid=b_valid=1 continuously.
//   -> grants alternate A,B,A,...
//   -> after a completes, only b is accepted.
//   -> data_ready pulses once, A+B cycles after the first accept (864 with defaults).
//   -> tiles_loaded=1.
//  3 Address/data check: a sends 0..287, b sends 1000..1575.
//   -> memory model holds a at 0..287 and b at 512..1087, all in order, each address written once.
//  4 Backpressure/bursty: random valid gaps on both streams, 2 back-to-back tiles.
//   -> no loss or duplication, data_ready twice, tiles_loaded=2.
//   -> start pulsed mid-tile is ignored.
//  5 Reset mid-operation: arst_in asserted after a_cnt=100.
//   -> outputs 0 asynchronously.
//   -> next start reloads from addr 0 and B_BASE_ADDR.
//  6 With LOAD_ARB_B_PRIORITY_EN and both valid: the first 576 accepts are all b, then 288 a; data_ready after the final a write.

Source files
------------

// File: rtl/ab_load_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_arb_pkg
// Description : Shared types for the tile load arbiter. Holds the FSM state
//               encoding, the stream identifier that round-robin arbitration
//               keeps as its last grant, and the tile counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package load_arb_pkg;

  typedef enum logic [1:0] {
    LA_IDLE = 2'd0,
    LA_LOAD = 2'd1,
    LA_DONE = 2'd2
  } load_arb_state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam int TILES_CNT_W = 16;

endpackage : load_arb_pkg
`default_nettype wire

// File: rtl/ab_load_arbiter_tile_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : tile_word_counter
// Description : Beat counter for one input stream of the tile loader. Counts
//               accepted beats up to MAX and saturates there. Clear has
//               priority over increment.
// Ports       : clk      - clock, rising edge
//               arst_in  - asynchronous reset, active-high
//               clear_i  - synchronous clear to 0
//               inc_i    - count one accepted beat
//               count_o  - beats accepted so far in this tile
//               full_o   - count_o == MAX (stream complete)
// Revision    : 1.0 - initial release
// ============================================================================
module tile_word_counter
  import load_arb_pkg::*;
#(
  parameter int MAX = 288,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         arst_in,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         full_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign full_o  = (count_q == W'(MAX));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !full_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : tile_word_counter
`default_nettype wire

// File: rtl/ab_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ab_load_arbiter
// Description : Shares the single internal-memory write port between the
//               activation (a) and weight (b) valid/ready streams while one
//               tile is loaded. a beats land at 0.., b beats at B_BASE_ADDR..
//               data_ready pulses once when both streams delivered a tile.
// Config      : LOAD_ARB_B_PRIORITY_EN defined   -> b has fixed priority
//               LOAD_ARB_B_PRIORITY_EN undefined -> round-robin (default)
// Ports       : clk, arst_in (async, active-high)
//               start            - begin one tile (only honoured in IDLE)
//               busy             - high in LOAD and DONE
//               a_valid/a_data/a_ready, b_valid/b_data/b_ready - streams
//               mem_we/mem_waddr/mem_wdata - registered memory write port
//               data_ready       - one-cycle tile-complete pulse
//               tiles_loaded     - completed tiles, wraps at 2**16
// Revision    : 1.0 - initial release
// ============================================================================
module ab_load_arbiter
  import load_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int A_TILE_WORDS = 288,
  parameter int B_TILE_WORDS = 576,
  // Must be >= A_TILE_WORDS and the b region must fit in 2**ADDR_WIDTH.
  parameter int B_BASE_ADDR  = 512
) (
  input  logic                   clk,
  input  logic                   arst_in,
  input  logic                   start,
  output logic                   busy,
  input  logic                   a_valid,
  input  logic [DATA_WIDTH-1:0]  a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [DATA_WIDTH-1:0]  b_data,
  output logic                   b_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   data_ready,
  output logic [TILES_CNT_W-1:0] tiles_loaded
);

  localparam int A_CW = $clog2(A_TILE_WORDS + 1);
  localparam int B_CW = $clog2(B_TILE_WORDS + 1);

  load_arb_state_t state_q;
  load_arb_state_t state_d;

  logic [A_CW-1:0] a_cnt;
  logic [B_CW-1:0] b_cnt;
  logic            a_full;
  logic            b_full;
  logic            cnt_clear;

  logic a_elig;
  logic b_elig;
  logic a_grant;
  logic b_grant;
  logic tile_done;

  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_waddr_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic [TILES_CNT_W-1:0] tiles_q;

  // --------------------------------------------------------------------------
  // Per-stream beat counters
  // --------------------------------------------------------------------------
  assign cnt_clear = (state_q == LA_DONE);

  tile_word_counter #(
    .MAX (A_TILE_WORDS),
    .W   (A_CW)
  ) u_a_cnt (
    .clk     (clk),
    .arst_in (arst_in),
    .clear_i (cnt_clear),
    .inc_i   (a_grant),
    .count_o (a_cnt),
    .full_o  (a_full)
  );

  tile_word_counter #(
    .MAX (B_TILE_WORDS),
    .W   (B_CW)
  ) u_b_cnt (
    .clk     (clk),
    .arst_in (arst_in),
    .clear_i (cnt_clear),
    .inc_i   (b_grant),
    .count_o (b_cnt),
    .full_o  (b_full)
  );

  // --------------------------------------------------------------------------
  // Arbitration. A completed stream is never eligible, so its ready stays 0.
  // --------------------------------------------------------------------------
  assign a_elig = (state_q == LA_LOAD) && a_valid && !a_full;
  assign b_elig = (state_q == LA_LOAD) && b_valid && !b_full;

`ifdef LOAD_ARB_B_PRIORITY_EN
  always_comb begin
    b_grant = b_elig;
    a_grant = a_elig && !b_elig;
  end
`else
  grant_t last_grant_q;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (a_elig && b_elig) begin
      // Contention: serve the stream that did not win last time.
      if (last_grant_q == GRANT_B) begin
        a_grant = 1'b1;
      end else begin
        b_grant = 1'b1;
      end
    end else begin
      a_grant = a_elig;
      b_grant = b_elig;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      last_grant_q <= GRANT_B;
    end else if (a_grant) begin
      last_grant_q <= GRANT_A;
    end else if (b_grant) begin
      last_grant_q <= GRANT_B;
    end
  end
`endif

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // Tile completion looks at the counts as they will be after this cycle's
  // beat, so DONE lands in the same cycle as the final memory write.
  assign tile_done =
    (a_full || (a_grant && (a_cnt == A_CW'(A_TILE_WORDS - 1)))) &&
    (b_full || (b_grant && (b_cnt == B_CW'(B_TILE_WORDS - 1))));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LA_IDLE: if (start)     state_d = LA_LOAD;
      LA_LOAD: if (tile_done) state_d = LA_DONE;
      LA_DONE:                state_d = LA_IDLE;
      default:                state_d = LA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q <= LA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Registered memory write port and tile counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      tiles_q     <= '0;
    end else begin
      mem_we_q <= a_grant || b_grant;
      if (a_grant) begin
        mem_waddr_q <= ADDR_WIDTH'(a_cnt);
        mem_wdata_q <= a_data;
      end else if (b_grant) begin
        mem_waddr_q <= ADDR_WIDTH'(B_BASE_ADDR) + ADDR_WIDTH'(b_cnt);
        mem_wdata_q <= b_data;
      end
      if ((state_q == LA_LOAD) && tile_done) begin
        tiles_q <= tiles_q + TILES_CNT_W'(1);
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign tiles_loaded = tiles_q;
  assign busy         = (state_q != LA_IDLE);
  assign data_ready   = (state_q == LA_DONE);

endmodule : ab_load_arbiter
`default_nettype wire

// File: tb/tb_ab_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_load_arbiter
// Description : Self-checking bench for ab_load_arbiter. Random valid patterns
//               drive both streams; a count-based reference model predicts
//               grants, memory writes, data_ready and tiles_loaded each cycle.
//               Build with LOAD_ARB_B_PRIORITY_EN to check the b-priority mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_load_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int AT = 288;
  localparam int BT = 576;
  localparam int BB = 512;

  logic          clk;
  logic          arst_in;
  logic          start;
  logic          busy;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          data_ready;
  logic [15:0]   tiles_loaded;

  ab_load_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .A_TILE_WORDS (AT),
    .B_TILE_WORDS (BT),
    .B_BASE_ADDR  (BB)
  ) dut (
    .clk          (clk),
    .arst_in      (arst_in),
    .start        (start),
    .busy         (busy),
    .a_valid      (a_valid),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .data_ready   (data_ready),
    .tiles_loaded (tiles_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase (0 idle, 1 loading, 2 tile complete), beats
  // delivered per stream, who won the last contention, pending write.
  int   m_state;
  int   m_a;
  int   m_b;
  int   m_tiles;
  logic m_last_b;
  logic m_pwe;
  int   m_paddr;
  int   m_pdata;

  int mem_val[4096];
  int mem_cnt[4096];
  int seq[$];      // observed accept order: 0 = a, 1 = b
  int first_acc;
  int last_acc;
  int dr_cyc;
  int dr_seen;

  task automatic model_reset();
    m_state  = 0;
    m_a      = 0;
    m_b      = 0;
    m_tiles  = 0;
    m_last_b = 1'b1;
    m_pwe    = 1'b0;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 4096; i++) begin
      mem_val[i] = 0;
      mem_cnt[i] = 0;
    end
  endtask

  // Drives one tile (or until stop_a a beats when stop_a >= 0), comparing
  // every cycle against the model. start is pulsed at cycle 0 and mid_at.
  task automatic run_tile(input int pa, input int pb, input int stop_a,
                          input int mid_at, input int a_base, input int b_base);
    int   cyc;
    logic finished;
    logic ea, eb, ga, gb;
    cyc = 0;
    finished = 1'b0;
    first_acc = -1;
    last_acc = -1;
    dr_cyc = -1;
    seq.delete();
    while (!finished && cyc < 20000) begin
      start   = (cyc == 0) || (cyc == mid_at);
      a_valid = ($urandom_range(99) < pa);
      b_valid = ($urandom_range(99) < pb);
      a_data  = DW'(a_base + m_a);
      b_data  = DW'(b_base + m_b);
      ea = (m_state == 1) && a_valid && (m_a < AT);
      eb = (m_state == 1) && b_valid && (m_b < BT);
`ifdef LOAD_ARB_B_PRIORITY_EN
      gb = eb;
      ga = ea && !eb;
`else
      if (ea && eb) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = ea;
        gb = eb;
      end
`endif
      @(negedge clk);
      n_checks++;
      if (a_ready !== ga || b_ready !== gb) begin
        $display("FAIL grant cyc=%0d got a_ready=%0b b_ready=%0b exp %0b %0b a_cnt=%0d b_cnt=%0d",
                 cyc, a_ready, b_ready, ga, gb, m_a, m_b);
      end else n_pass++;
      n_checks++;
      if (busy !== (m_state != 0) || data_ready !== (m_state == 2)) begin
        $display("FAIL status cyc=%0d got busy=%0b data_ready=%0b exp %0b %0b",
                 cyc, busy, data_ready, (m_state != 0), (m_state == 2));
      end else n_pass++;
      n_checks++;
      if (mem_we !== m_pwe ||
          (m_pwe && (mem_waddr !== AW'(m_paddr) || mem_wdata !== DW'(m_pdata)))) begin
        $display("FAIL memwrite cyc=%0d got we=%0b addr=%0d data=%0d exp we=%0b addr=%0d data=%0d",
                 cyc, mem_we, mem_waddr, mem_wdata, m_pwe, m_paddr, m_pdata);
      end else n_pass++;
      n_checks++;
      if (tiles_loaded !== 16'(m_tiles)) begin
        $display("FAIL tiles cyc=%0d got %0d exp %0d", cyc, tiles_loaded, 16'(m_tiles));
      end else n_pass++;
      if (mem_we === 1'b1) begin
        mem_val[mem_waddr] = int'(mem_wdata);
        mem_cnt[mem_waddr]++;
      end
      if (a_valid && a_ready) seq.push_back(0);
      if (b_valid && b_ready) seq.push_back(1);
      if ((a_valid && a_ready) || (b_valid && b_ready)) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (data_ready === 1'b1) begin
        dr_seen++;
        if (dr_cyc < 0) dr_cyc = cyc;
      end
      // advance model
      m_pwe   = ga || gb;
      m_paddr = ga ? m_a : BB + m_b;
      m_pdata = ga ? int'(a_data) : int'(b_data);
      if (ga) begin m_a++; m_last_b = 1'b0; end
      if (gb) begin m_b++; m_last_b = 1'b1; end
      case (m_state)
        0: if (start) m_state = 1;
        1: if (m_a == AT && m_b == BT) begin m_state = 2; m_tiles++; end
        default: begin m_state = 0; m_a = 0; m_b = 0; finished = 1'b1; end
      endcase
      if (stop_a >= 0 && m_a >= stop_a) finished = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    n_checks++;
    if (!finished) $display("FAIL tile_timeout got cycles=%0d exp completion", cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    arst_in = 1'b1;
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, a_ready, b_ready, mem_we, data_ready} !== 5'b0 ||
          mem_waddr !== '0 || mem_wdata !== '0 || tiles_loaded !== '0) begin
        $display("FAIL reset_outputs got busy=%0b we=%0b addr=%0d data=%0d tiles=%0d exp all 0",
                 busy, mem_we, mem_waddr, mem_wdata, tiles_loaded);
      end else n_pass++;
    end
    @(posedge clk); #1;
    arst_in = 1'b0;
    model_reset();
    // start with no valid: busy rises, nothing is written
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_state = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || mem_we !== 1'b0 || data_ready !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bad != 0) $display("FAIL idle_load got bad_cycles=%0d exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_contention();
    int bad;
    run_tile(100, 100, -1, -1, 16'h0100, 16'h4000);
    bad = 0;
`ifdef LOAD_ARB_B_PRIORITY_EN
    for (int k = 0; k < seq.size(); k++) if (seq[k] != ((k < BT) ? 1 : 0)) bad++;
    n_checks++;
    if (dr_cyc != last_acc + 1)
      $display("FAIL prio_done_timing got dr=%0d exp %0d", dr_cyc, last_acc + 1);
    else n_pass++;
`else
    for (int k = 0; k < seq.size(); k++) if (seq[k] != ((k < 2 * AT) ? (k % 2) : 1)) bad++;
`endif
    n_checks++;
    if (bad != 0 || seq.size() != AT + BT)
      $display("FAIL grant_order got bad=%0d accepts=%0d exp 0 %0d", bad, seq.size(), AT + BT);
    else n_pass++;
    n_checks++;
    if (dr_cyc - first_acc != AT + BT)
      $display("FAIL done_latency got %0d exp %0d", dr_cyc - first_acc, AT + BT);
    else n_pass++;
    n_checks++;
    if (tiles_loaded !== 16'd1) $display("FAIL tiles_after_1 got %0d exp 1", tiles_loaded);
    else n_pass++;
  endtask

  task automatic test_addr_data();
    int bad_a, bad_b, bad_gap;
    mem_clear();
    run_tile(100, 100, -1, -1, 0, 1000);
    bad_a = 0; bad_b = 0; bad_gap = 0;
    for (int i = 0; i < AT; i++) if (mem_val[i] != i || mem_cnt[i] != 1) bad_a++;
    for (int i = 0; i < BT; i++) if (mem_val[BB + i] != 1000 + i || mem_cnt[BB + i] != 1) bad_b++;
    for (int i = AT; i < BB; i++) if (mem_cnt[i] != 0) bad_gap++;
    for (int i = BB + BT; i < 4096; i++) if (mem_cnt[i] != 0) bad_gap++;
    n_checks++;
    if (bad_a != 0) $display("FAIL a_region got bad=%0d exp 0", bad_a); else n_pass++;
    n_checks++;
    if (bad_b != 0) $display("FAIL b_region got bad=%0d exp 0", bad_b); else n_pass++;
    n_checks++;
    if (bad_gap != 0) $display("FAIL stray_writes got %0d exp 0", bad_gap); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t0, bad;
    mem_clear();
    t0 = m_tiles;
    dr_seen = 0;
    run_tile(60, 55, -1, 137, int'($urandom_range(30000)), int'($urandom_range(30000)));
    run_tile(45, 70, -1, 400, int'($urandom_range(30000)), int'($urandom_range(30000)));
    bad = 0;
    for (int i = 0; i < AT; i++) if (mem_cnt[i] != 2) bad++;
    for (int i = 0; i < BT; i++) if (mem_cnt[BB + i] != 2) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL b2b_write_counts got bad=%0d exp 0", bad); else n_pass++;
    n_checks++;
    if (dr_seen != 2) $display("FAIL b2b_data_ready got %0d exp 2", dr_seen); else n_pass++;
    n_checks++;
    if (tiles_loaded !== 16'(t0 + 2))
      $display("FAIL b2b_tiles got %0d exp %0d", tiles_loaded, t0 + 2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_tile(80, 80, 100, -1, 5, 7000);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #2;
    arst_in = 1'b1;
    #1;
    n_checks++;
    if ({busy, a_ready, b_ready, mem_we, data_ready} !== 5'b0 || tiles_loaded !== '0)
      $display("FAIL async_reset got busy=%0b ar=%0b br=%0b we=%0b dr=%0b tiles=%0d exp all 0",
               busy, a_ready, b_ready, mem_we, data_ready, tiles_loaded);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_in = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    model_reset();
    mem_clear();
    run_tile(70, 70, -1, -1, 20, 9000);
    n_checks++;
    if (mem_cnt[0] != 1 || mem_val[0] != 20 || mem_cnt[BB] != 1 || mem_val[BB] != 9000)
      $display("FAIL reload_base got a0=%0d/%0d b0=%0d/%0d exp 20/1 9000/1",
               mem_val[0], mem_cnt[0], mem_val[BB], mem_cnt[BB]);
    else n_pass++;
    n_checks++;
    if (tiles_loaded !== 16'd1) $display("FAIL tiles_after_reset got %0d exp 1", tiles_loaded);
    else n_pass++;
  endtask

  initial begin
    dr_seen = 0;
    model_reset();
    mem_clear();
    test_reset();
    test_contention();
    test_addr_data();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got time limit exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ab_load_arbiter
`default_nettype wire
